// File: rtl/game_flow_controller_if.sv
// Handshake bundle between the game sequencer and the testbench/playfield side.
// The slave modport is the controller's view; master drives start/colision.
interface game_flow_controller_if;
    logic       start;
    logic       colision;
    logic       upsig;
    logic       upsig_fast;
    logic       drop;
    logic       alive;
    logic [1:0] lives;
    logic [1:0] state_dbg;

    modport master (
        output start, colision,
        input  upsig, upsig_fast, drop, alive, lives, state_dbg
    );

    modport slave (
        input  start, colision,
        output upsig, upsig_fast, drop, alive, lives, state_dbg
    );
endinterface

// File: rtl/game_flow_controller.sv
// Game-level sequencer: tick dividers, lives/crash/grace FSM and LFSR-driven
// obstacle drops. All outputs are registered from the next state.
module game_flow_controller #(
    parameter int UPD_DIV      = 833333,
    parameter int FAST_DIV     = 416667,
    parameter int LIVES        = 3,
    parameter int CRASH_TICKS  = 90,
    parameter int GRACE_TICKS  = 60,
    parameter int DROP_GAP_MIN = 20,
    parameter int DROP_GAP_MAX = 80
) (
    input logic                  clk,
    input logic                  reset,
    game_flow_controller_if.slave gf
);
    localparam int SW = (UPD_DIV  > 1) ? $clog2(UPD_DIV)  : 1;
    localparam int FW = (FAST_DIV > 1) ? $clog2(FAST_DIV) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, CRASH = 2'd2, OVER = 2'd3} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] div_s_q;
    logic [FW-1:0] div_f_q;
    logic          start_meta_q, start_sync_q, start_prev_q, start_pe_q;
    logic [1:0]    lives_q, lives_d;
    logic [7:0]    crash_q, crash_d;
    logic [7:0]    grace_q, grace_d;
    logic [7:0]    gap_q, gap_d, gap_inc;
    logic [15:0]   lfsr_q, lfsr_d;
    logic          upsig_q, upsig_fast_q, drop_q, alive_q;
    logic          tick_s, tick_f, drop_c, lfsr_fb;

    assign tick_s  = (div_s_q == SW'(UPD_DIV - 1));
    assign tick_f  = (div_f_q == FW'(FAST_DIV - 1));
    assign gap_inc = (gap_q == 8'hFF) ? gap_q : gap_q + 8'd1;
    assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    assign lfsr_d  = tick_s ? {lfsr_fb, lfsr_q[15:1]} : lfsr_q;

    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        crash_d = crash_q;
        grace_d = grace_q;
        gap_d   = gap_q;
        drop_c  = 1'b0;
        case (state_q)
            IDLE, OVER: begin
                if (start_pe_q) begin
                    state_d = RUN;
                    lives_d = 2'(LIVES);
                    gap_d   = '0;
                    grace_d = '0;
                end
            end
            RUN: begin
                // Crash wins over a coincident tick: no grace/gap/drop work this cycle.
                if (gf.colision && grace_q == 8'd0) begin
                    state_d = CRASH;
                    lives_d = (lives_q != 2'd0) ? lives_q - 2'd1 : lives_q;
                    crash_d = 8'(CRASH_TICKS);
                end else if (tick_s) begin
                    if (grace_q != 8'd0) grace_d = grace_q - 8'd1;
                    if ((gap_inc >= 8'(DROP_GAP_MIN) && lfsr_q[3:0] == 4'd0) ||
                        gap_inc == 8'(DROP_GAP_MAX)) begin
                        drop_c = 1'b1;
                        gap_d  = '0;
                    end else begin
                        gap_d  = gap_inc;
                    end
                end
            end
            CRASH: begin
                if (tick_s) begin
                    crash_d = (crash_q != 8'd0) ? crash_q - 8'd1 : crash_q;
                    if (crash_q <= 8'd1) begin
                        if (lives_q != 2'd0) begin
                            state_d = RUN;
                            grace_d = 8'(GRACE_TICKS);
                        end else begin
                            state_d = OVER;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            div_s_q      <= '0;
            div_f_q      <= '0;
            start_meta_q <= 1'b0;
            start_sync_q <= 1'b0;
            start_prev_q <= 1'b0;
            start_pe_q   <= 1'b0;
            lives_q      <= 2'(LIVES);
            crash_q      <= '0;
            grace_q      <= '0;
            gap_q        <= '0;
            lfsr_q       <= 16'hACE1;
            upsig_q      <= 1'b0;
            upsig_fast_q <= 1'b0;
            drop_q       <= 1'b0;
            alive_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_s_q      <= tick_s ? '0 : div_s_q + SW'(1);
            div_f_q      <= tick_f ? '0 : div_f_q + FW'(1);
            start_meta_q <= gf.start;
            start_sync_q <= start_meta_q;
            start_prev_q <= start_sync_q;
            start_pe_q   <= start_sync_q & ~start_prev_q;
            lives_q      <= lives_d;
            crash_q      <= crash_d;
            grace_q      <= grace_d;
            gap_q        <= gap_d;
            lfsr_q       <= lfsr_d;
            upsig_q      <= tick_s & (state_d == RUN);
            upsig_fast_q <= tick_f & (state_d == RUN);
            drop_q       <= drop_c & (state_d == RUN);
            alive_q      <= (state_d == RUN);
        end
    end

    assign gf.upsig      = upsig_q;
    assign gf.upsig_fast = upsig_fast_q;
    assign gf.drop       = drop_q;
    assign gf.alive      = alive_q;
    assign gf.lives      = lives_q;
    assign gf.state_dbg  = state_q;
endmodule

// File: tb/tb_game_flow_controller.sv
// Randomized start/colision stimulus against a per-edge behavioural model of the
// game rules; outputs compared every cycle and on asynchronous resets.
module tb_game_flow_controller;
    localparam int UPD_DIV = 4, FAST_DIV = 2, LIVES = 2, CRASH_TICKS = 3;
    localparam int GRACE_TICKS = 2, GMIN = 2, GMAX = 5;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0, failures = 0;
    int   crash_resets = 0, drops_seen = 0, overs_seen = 0;

    game_flow_controller_if gf();

    game_flow_controller #(
        .UPD_DIV(UPD_DIV), .FAST_DIV(FAST_DIV), .LIVES(LIVES),
        .CRASH_TICKS(CRASH_TICKS), .GRACE_TICKS(GRACE_TICKS),
        .DROP_GAP_MIN(GMIN), .DROP_GAP_MAX(GMAX)
    ) dut (
        .clk(clk), .reset(reset), .gf(gf)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 idle, 1 playing, 2 crashed, 3 game over.
    int          m_mode, m_lives, m_crash, m_grace, m_gap, m_edges;
    logic [15:0] m_lfsr;
    logic        m_up, m_upf, m_drop, m_alive;
    logic        m_hist[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_lives = LIVES; m_crash = 0; m_grace = 0; m_gap = 0;
        m_edges = 0; m_lfsr = 16'hACE1;
        m_up = 0; m_upf = 0; m_drop = 0; m_alive = 0;
        m_hist = {1'b0, 1'b0, 1'b0, 1'b0};
    endtask

    task automatic model_step(input logic st, input logic col);
        bit tick, tickf, pe, dc;
        int nm, g;
        tick  = (m_edges % UPD_DIV) == UPD_DIV - 1;
        tickf = (m_edges % FAST_DIV) == FAST_DIV - 1;
        m_edges++;
        // synchronizer + registered edge detect: raw seen 3 edges ago, not 4
        pe = m_hist[$-2] && !m_hist[$-3];
        m_hist.push_back(st);
        nm = m_mode;
        dc = 0;
        if (m_mode == 0 || m_mode == 3) begin
            if (pe) begin nm = 1; m_lives = LIVES; m_gap = 0; m_grace = 0; end
        end else if (m_mode == 1) begin
            if (col && m_grace == 0) begin
                nm = 2;
                if (m_lives > 0) m_lives--;
                m_crash = CRASH_TICKS;
            end else if (tick) begin
                if (m_grace > 0) m_grace--;
                g = (m_gap < 255) ? m_gap + 1 : 255;
                if ((g >= GMIN && m_lfsr % 16 == 0) || g == GMAX) begin
                    dc = 1; m_gap = 0;
                end else m_gap = g;
            end
        end else if (tick) begin
            m_crash--;
            if (m_crash == 0) begin
                if (m_lives > 0) begin nm = 1; m_grace = GRACE_TICKS; end
                else nm = 3;
            end
        end
        if (tick) m_lfsr = {^(m_lfsr & 16'h002D), m_lfsr[15:1]};
        m_mode  = nm;
        m_up    = tick && nm == 1;
        m_upf   = tickf && nm == 1;
        m_drop  = dc;
        m_alive = nm == 1;
        if (dc) drops_seen++;
        if (nm == 3) overs_seen++;
    endtask

    task automatic check_outputs(input string pfx);
        chk({pfx, "upsig"},      32'(gf.upsig),      32'(m_up));
        chk({pfx, "upsig_fast"}, 32'(gf.upsig_fast), 32'(m_upf));
        chk({pfx, "drop"},       32'(gf.drop),       32'(m_drop));
        chk({pfx, "alive"},      32'(gf.alive),      32'(m_alive));
        chk({pfx, "lives"},      32'(gf.lives),      32'(m_lives));
        chk({pfx, "state_dbg"},  32'(gf.state_dbg),  32'(m_mode));
    endtask

    // Entered and left at a negedge; reset takes effect without a clock edge.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs("rst_");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int st_cnt, col_cnt, col_rate;
        st_cnt = 0; col_cnt = 0;
        reset = 1'b0;
        gf.start = 1'b0;
        gf.colision = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 6000; i++) begin
            col_rate = (i < 2000) ? 150 : 18;
            if (m_mode == 2 && $urandom_range(0, 59) == 0) begin
                do_reset();
                crash_resets++;
            end
            if (st_cnt > 0) st_cnt--;
            else if ($urandom_range(0, 24) == 0) st_cnt = $urandom_range(1, 4);
            if (col_cnt > 0) col_cnt--;
            else if ($urandom_range(0, col_rate) == 0) col_cnt = $urandom_range(1, 14);
            gf.start    = (st_cnt > 0);
            gf.colision = (col_cnt > 0);
            @(posedge clk);
            model_step(gf.start, gf.colision);
            @(negedge clk);
            check_outputs("");
        end
        // The random run must have exercised the drop path, game over and a crash-time reset.
        chk("drops_exercised", 32'(drops_seen > 0), 32'd1);
        chk("over_exercised",  32'(overs_seen > 0), 32'd1);
        chk("crash_reset_exercised", 32'(crash_resets > 0), 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
